mmio_responder: RTL and testbench

//  AFU-side slave for the PSL MMIO interface: consumes CAPI::MMIOInterfaceInput, returns CAPI::MMIOInterfaceOutput.

---
 rtl/mmio_responder.sv | 131 +++++++++++++
 tb/tb_mmio_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// PSL MMIO slave: 64-bit register file plus read-only AFU descriptor, odd parity check/generate, sticky error flags.
// Ack arrives two cycles after the accepted valid; no backpressure, so a valid seen while busy is dropped and flagged.
module mmio_responder #(
  parameter int          NUM_REGS   = 16,
  parameter logic [63:0] DESC_WORD0 = 64'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [93:0]              mmio_in,
  output logic [65:0]              mmio_out,
  output logic [64*NUM_REGS-1:0]   regs,
  output logic                     reg_wr,
  output logic [7:0]               reg_wr_index,
  output logic                     parity_error,
  output logic                     protocol_error
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef struct packed {
    logic        valid;
    logic        cfg;
    logic        read;
    logic        doubleword;
    logic [0:23] address;
    logic        address_parity;
    logic [0:63] data;
    logic        data_parity;
  } mmio_req_t;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  mmio_req_t   req;
  state_t      state, state_nxt;

  logic        cfg_q, read_q, dw_q, addr_par_q, wpar_q;
  logic [23:0] addr_q;
  logic [63:0] wdat_q;
  logic [63:0] rf [NUM_REGS];
  logic        ack_q;
  logic [63:0] data_q;

  logic [22:0] dw_idx;
  logic        word_sel, addr_bad, data_bad, par_bad, misalign, in_range, wr_ok;
  logic [63:0] cur, src, rdata, wr_val;
  logic [31:0] half;

  assign req = mmio_in;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req.valid) state_nxt = CHECK;
      CHECK:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // addr_q is stored numerically, so bit 0 is big-endian address[23] (the word select).
  always_comb begin
    dw_idx   = addr_q[23:1];
    word_sel = addr_q[0];
    addr_bad = addr_par_q != ~^addr_q;
    data_bad = ~read_q && (wpar_q != ~^wdat_q);
    par_bad  = addr_bad | data_bad;
    misalign = dw_q & word_sel;
    in_range = dw_idx < 23'(NUM_REGS);
    wr_ok    = (state == CHECK) && !read_q && !cfg_q && !par_bad && !misalign && in_range;
    cur      = in_range ? rf[dw_idx[IW-1:0]] : 64'h0;
    if (cfg_q) src = (dw_idx == 23'd0) ? DESC_WORD0 : 64'h0;
    else       src = cur;
    half     = word_sel ? src[31:0] : src[63:32];
    if (par_bad)       rdata = 64'h0;
    else if (misalign) rdata = {64{1'b1}};
    else if (dw_q)     rdata = src;
    else               rdata = {half, half};
    if (dw_q)          wr_val = wdat_q;
    else if (word_sel) wr_val = {cur[63:32], wdat_q[31:0]};
    else               wr_val = {wdat_q[31:0], cur[31:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_q          <= 1'b0;
      read_q         <= 1'b0;
      dw_q           <= 1'b0;
      addr_q         <= 24'h0;
      addr_par_q     <= 1'b0;
      wdat_q         <= 64'h0;
      wpar_q         <= 1'b0;
      ack_q          <= 1'b0;
      data_q         <= 64'h0;
      parity_error   <= 1'b0;
      protocol_error <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 64'h0;
    end else begin
      if (state == IDLE && req.valid) begin
        cfg_q      <= req.cfg;
        read_q     <= req.read;
        dw_q       <= req.doubleword;
        addr_q     <= req.address;
        addr_par_q <= req.address_parity;
        wdat_q     <= req.data;
        wpar_q     <= req.data_parity;
      end
      ack_q <= (state == CHECK);
      if (state == CHECK) begin
        data_q <= read_q ? rdata : 64'h0;
        if (par_bad)  parity_error   <= 1'b1;
        if (misalign) protocol_error <= 1'b1;
      end
      if (state != IDLE && req.valid) protocol_error <= 1'b1;
      if (wr_ok) rf[dw_idx[IW-1:0]] <= wr_val;
    end
  end

  assign reg_wr       = wr_ok & ~reset;
  assign reg_wr_index = dw_idx[7:0];
  assign mmio_out     = {ack_q, data_q, ~^data_q};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[64*g +: 64] = rf[g];
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: hand-computed vectors for writes, reads, parity, cfg, protocol and reset cases.
module tb_mmio_responder;

  logic              clock = 1'b0;
  logic              reset;
  logic [93:0]       mmio_in;
  logic [65:0]       mmio_out;
  logic [64*16-1:0]  regs;
  logic              reg_wr;
  logic [7:0]        reg_wr_index;
  logic              parity_error;
  logic              protocol_error;

  int n_checks = 0;
  int n_errors = 0;

  mmio_responder #(
    .NUM_REGS   (16),
    .DESC_WORD0 (64'h0001_0001_0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mmio_in        (mmio_in),
    .mmio_out       (mmio_out),
    .regs           (regs),
    .reg_wr         (reg_wr),
    .reg_wr_index   (reg_wr_index),
    .parity_error   (parity_error),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [93:0] mk(input logic cfg, input logic rd, input logic dw,
                                     input logic [23:0] addr, input logic [63:0] d,
                                     input logic bad_ap, input logic bad_dp);
    return {1'b1, cfg, rd, dw, addr, (~^addr) ^ bad_ap, d, (~^d) ^ bad_dp};
  endfunction

  // One request: valid for a single cycle T, observe T..T+3.
  task automatic do_req(input logic [93:0] r, output logic [3:0] acks, output logic wr_any,
                        output logic [7:0] wr_idx, output logic [63:0] rdata, output logic rpar);
    acks = 4'b0; wr_any = 1'b0; wr_idx = 8'h0; rdata = 64'h0; rpar = 1'b0;
    @(posedge clock); #1 mmio_in = r;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      acks[c] = mmio_out[65];
      if (reg_wr) begin wr_any = 1'b1; wr_idx = reg_wr_index; end
      if (c == 2) begin rdata = mmio_out[64:1]; rpar = mmio_out[0]; end
      @(posedge clock); #1 mmio_in = '0;
    end
  endtask

  logic [3:0]  acks;
  logic [5:0]  acks6;
  logic        wr_any, rpar;
  logic [7:0]  wr_idx;
  logic [63:0] rdata;
  int          late_acks;

  initial begin
    reset   = 1'b1;
    mmio_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ack", {63'b0, mmio_out[65]}, 64'h0);
    check("rst_data", mmio_out[64:1], 64'h0);
    check("rst_par", {63'b0, mmio_out[0]}, 64'h1);
    check("rst_regs_any", {63'b0, |regs}, 64'h0);
    check("rst_flags", {61'b0, reg_wr, parity_error, protocol_error}, 64'h0);

    // 1: DW write then DW read of idx 3
    do_req(mk(0, 0, 1, 24'd6, 64'h0123_4567_89AB_CDEF, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t1_wr_acks", {60'b0, acks}, 64'h4);
    check("t1_reg_wr", {63'b0, wr_any}, 64'h1);
    check("t1_reg_wr_index", {56'b0, wr_idx}, 64'h3);
    do_req(mk(0, 1, 1, 24'd6, 64'h0, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t1_rd_acks", {60'b0, acks}, 64'h4);
    check("t1_rd_data", rdata, 64'h0123_4567_89AB_CDEF);
    check("t1_rd_par", {63'b0, rpar}, 64'h1);

    // 2: word write low half of idx 3, then word read
    do_req(mk(0, 0, 0, 24'd7, 64'h0000_0000_DEAD_BEEF, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t2_wr_acks", {60'b0, acks}, 64'h4);
    check("t2_reg_wr_index", {55'b0, wr_any, wr_idx}, 64'h103);
    check("t2_reg3", regs[3*64 +: 64], 64'h0123_4567_DEAD_BEEF);
    do_req(mk(0, 1, 0, 24'd7, 64'h0, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t2_rd_data", rdata, 64'hDEAD_BEEF_DEAD_BEEF);
    check("t2_rd_par", {63'b0, rpar}, 64'h1);

    // 3: bad address parity on write to idx 2
    do_req(mk(0, 0, 1, 24'd4, 64'h1111_2222_3333_4444, 1, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t3_acks", {60'b0, acks}, 64'h4);
    check("t3_no_reg_wr", {63'b0, wr_any}, 64'h0);
    check("t3_reg2", regs[2*64 +: 64], 64'h0);
    check("t3_flags", {62'b0, parity_error, protocol_error}, 64'h2);
    do_req(mk(0, 1, 1, 24'd4, 64'h0, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t3_rd_data", rdata, 64'h0);

    // 4: cfg descriptor read and dropped cfg write
    do_req(mk(1, 1, 1, 24'd0, 64'h0, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t4_cfg_acks", {60'b0, acks}, 64'h4);
    check("t4_cfg_data", rdata, 64'h0001_0001_0000_0000);
    check("t4_cfg_par", {63'b0, rpar}, 64'h1);
    do_req(mk(1, 0, 1, 24'd0, 64'hFFFF_0000_FFFF_0000, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t4_cfgwr_acks", {60'b0, acks}, 64'h4);
    check("t4_cfgwr_no_reg_wr", {63'b0, wr_any}, 64'h0);
    check("t4_proto_clear", {63'b0, protocol_error}, 64'h0);

    // 5: valid held three cycles yields one ack; then misaligned DW read
    acks6 = 6'b0;
    rdata = 64'h0;
    @(posedge clock); #1 mmio_in = mk(0, 1, 1, 24'd6, 64'h0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      acks6[c] = mmio_out[65];
      if (c == 2) rdata = mmio_out[64:1];
      @(posedge clock); #1;
      if (c == 2) mmio_in = '0;
    end
    check("t5_hold_acks", {58'b0, acks6}, 64'h04);
    check("t5_hold_data", rdata, 64'h0123_4567_DEAD_BEEF);
    check("t5_proto", {63'b0, protocol_error}, 64'h1);
    do_req(mk(0, 1, 1, 24'd7, 64'h0, 0, 0), acks, wr_any, wr_idx, rdata, rpar);
    check("t5_mis_acks", {60'b0, acks}, 64'h4);
    check("t5_mis_data", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_mis_par", {63'b0, rpar}, 64'h1);

    // 6: reset one cycle after a write's valid
    @(posedge clock); #1 mmio_in = mk(0, 0, 1, 24'd10, 64'hAAAA_5555_AAAA_5555, 0, 0);
    @(posedge clock); #1 reset = 1'b1; mmio_in = '0;
    @(negedge clock);
    check("t6_reg_wr_in_reset", {63'b0, reg_wr}, 64'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("t6_ack", {63'b0, mmio_out[65]}, 64'h0);
    check("t6_data", mmio_out[64:1], 64'h0);
    check("t6_par", {63'b0, mmio_out[0]}, 64'h1);
    check("t6_reg5", regs[5*64 +: 64], 64'h0);
    check("t6_regs_any", {63'b0, |regs}, 64'h0);
    check("t6_flags", {62'b0, parity_error, protocol_error}, 64'h0);
    late_acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (mmio_out[65]) late_acks++;
    end
    check("t6_no_late_ack", 64'(late_acks), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
